image_row_assembler: RTL and testbench
======================================

// Module: image_row_assembler
// PURPOSE
//  Upstream stage of the 64-bit image select mux in the OCR datapath.
//  Collects eight 8-bit binarised pixel rows into one 64-bit image word.
//  Holds up to two complete images in a ping-pong pair of banks.
//  Exposes both banks plus the read-bank select so the downstream 64-bit 2:1
//  mux presents the current image to the input layer of the network.
// PARAMETERS
//  IWIDTH   64  image word width (ROWS*ROWW)
//  ROWW      8  pixels per row
//  ROWS      8  rows per image
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst_n      in   1       synchronous active-low reset
//  row_valid  in   1       row_data/row_sof valid this cycle
//  row_ready  out  1       assembler can accept a row
//  row_sof    in   1       qualifies row_data as row 0 of a new image
//  row_data   in   ROWW    binarised pixels, bit7 = leftmost pixel
//  img_valid  out  1       read bank holds a complete image
//  img_ready  in   1       consumer (network input stage) takes the image
//  bank0      out  IWIDTH  image bank 0 contents (mux in1)
//  bank1      out  IWIDTH  image bank 1 contents (mux in2)
//  rd_sel     out  1       0: read bank0, 1: read bank1 (mux sel)
//  frame_err  out  1       one-cycle pulse: partial image discarded
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): bank0=bank1=0, wr_sel=rd_sel=0, row_cnt=0,
//   full[1:0]=0, img_valid=0, frame_err=0; row_ready=0 during the reset cycle.
//  row_ready = ~full[wr_sel] (combinational from registers).
//  Row accepted when row_valid&row_ready. Row r goes to bank[wr_sel]
//   bits [IWIDTH-1-ROWW*r -: ROWW]; row 0 is the MSB byte.
//  row_cnt 0..ROWS-1 increments per accepted row. When it wraps on row
//   ROWS-1: full[wr_sel]<=1, wr_sel toggles, row_cnt<=0.
//  row_sof on an accepted row with row_cnt!=0: the partial image is dropped.
//   The write bank is cleared, the row is stored as row 0, row_cnt<=1, and
//   frame_err pulses the following cycle.
//  row_sof with row_cnt==0 is normal. Rows without sof at row_cnt==0 are
//   accepted; sof is optional framing.
//  img_valid = full[rd_sel]. Handshake: img_valid&img_ready at an edge ->
//   full[rd_sel]<=0, rd_sel toggles. bankN contents are not cleared on
//   consume; they are overwritten by the next writes.
//  Latency: 8th row accepted at edge N -> img_valid=1 after edge N, provided
//   that bank is also the read bank; otherwise it waits behind the older image.
//  Completion and consume in the same cycle on different banks: both
//   take effect.
//  Both banks full: row_ready=0, and row_valid is ignored (no overwrite).
//  bank/rd_sel must stay stable while img_valid=1 and img_ready=0.
//  Reset mid-image or mid-handshake: all partial and complete images are lost.
//  Throughput: one row/cycle sustained; one image per 8 cycles.
// STRUCTURE
//  Shared package/include: IWIDTH, ROWW, ROWS, and row-count width
//   $clog2(ROWS), shared with the network input stage.
//  No sub-module required. The 64-bit 2:1 selection stays in the existing
//   downstream mux driven by bank0/bank1/rd_sel. Row-slice write enable is
//   a local generate loop.
// TESTING
//  1 Reset, then 8 rows 0x81,0x42,0x24,0x18,0x18,0x24,0x42,0x81 with sof on
//    the first row -> img_valid after 8th edge; bank0=64'h8142241818244281.
//    rd_sel=0.
//  2 img_ready held 0, feed 16 rows -> both full, row_ready=0.
//    A 17th row_valid is ignored; bank1 holds the 2nd image.
//  3 Consume from test 2 -> rd_sel 0->1, img_valid stays 1, row_ready=1.
//    Consume again -> img_valid=0.
//  4 3 rows, then a sof row 0xFF -> frame_err pulse 1 cycle. After 7 more
//    rows, bank MSB byte=0xFF and no stale rows remain.
//  5 8th row accept and img consume in the same cycle, both banks in use ->
//    full flags are exact, no image lost or duplicated.
//  6 rst_n=0 after 5 rows -> all outputs at reset values. A fresh 8-row image
//    completes normally in bank0.

Source files
------------

// File: rtl/image_row_assembler_pkg.sv
// Shared geometry of the binarised OCR image: row width, row count, word width
// and the row-counter type used by the assembler and the network input stage.
package image_row_assembler_pkg;

  localparam int ROWW   = 8;
  localparam int ROWS   = 8;
  localparam int IWIDTH = ROWS * ROWW;
  localparam int CNTW   = $clog2(ROWS);

  typedef logic [CNTW-1:0]   row_cnt_t;
  typedef logic [IWIDTH-1:0] image_t;

  localparam row_cnt_t ROW_FIRST = row_cnt_t'(0);
  localparam row_cnt_t ROW_LAST  = row_cnt_t'(ROWS - 1);

  // True when the counter points at the final row of an image.
  function automatic logic is_last_row(input row_cnt_t cnt);
    return (cnt == ROW_LAST);
  endfunction

endpackage

// File: rtl/image_row_assembler.sv
// Assembles eight 8-bit pixel rows into a 64-bit image word held in a
// ping-pong pair of banks. The downstream 2:1 mux picks bank0/bank1 via rd_sel.
module image_row_assembler
  import image_row_assembler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic              row_sof,
  input  logic [ROWW-1:0]   row_data,
  output logic              img_valid,
  input  logic              img_ready,
  output logic [IWIDTH-1:0] bank0,
  output logic [IWIDTH-1:0] bank1,
  output logic              rd_sel,
  output logic              frame_err
);

  // State registers
  image_t   bank0_r;
  image_t   bank1_r;
  logic     wr_sel_r;
  logic     rd_sel_r;
  row_cnt_t row_cnt_r;
  logic [1:0] full_r;
  logic     frame_err_r;

  // Next-state and datapath signals
  logic       acc_s;
  logic       drop_s;
  logic       done_s;
  logic       cons_s;
  row_cnt_t   wr_idx_s;
  row_cnt_t   row_cnt_nxt_s;
  logic [1:0] full_nxt_s;
  logic       wr_sel_nxt_s;
  logic       rd_sel_nxt_s;
  image_t     wbank_cur_s;
  image_t     wbank_base_s;
  image_t     wbank_nxt_s;
  logic [ROWS-1:0] row_we_s;

  // Ready is forced low while reset is being sampled so no row is taken then.
  assign row_ready = rst_n & ~full_r[wr_sel_r];
  assign img_valid = full_r[rd_sel_r];
  assign bank0     = bank0_r;
  assign bank1     = bank1_r;
  assign rd_sel    = rd_sel_r;
  assign frame_err = frame_err_r;

  assign acc_s       = row_valid & row_ready;
  assign drop_s      = acc_s & row_sof & (row_cnt_r != ROW_FIRST);
  assign done_s      = acc_s & ~drop_s & is_last_row(row_cnt_r);
  assign cons_s      = img_valid & img_ready;
  assign wr_idx_s    = drop_s ? ROW_FIRST : row_cnt_r;
  assign wbank_cur_s = wr_sel_r ? bank1_r : bank0_r;

  // Starting point of the write bank: a resynchronising sof wipes stale rows.
  always_comb begin
    wbank_base_s = wbank_cur_s;
    if (drop_s) begin
      wbank_base_s = {IWIDTH{1'b0}};
    end else begin
      wbank_base_s = wbank_cur_s;
    end
  end

  // Per-row slice write enables; row 0 lands in the MSB byte.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    assign row_we_s[g] = acc_s & (wr_idx_s == row_cnt_t'(g));
    assign wbank_nxt_s[IWIDTH-1-ROWW*g -: ROWW] =
      row_we_s[g] ? row_data : wbank_base_s[IWIDTH-1-ROWW*g -: ROWW];
  end

  // Row counter, bank-full flags and ping-pong selects for the next cycle.
  always_comb begin
    row_cnt_nxt_s = row_cnt_r;
    full_nxt_s    = full_r;
    wr_sel_nxt_s  = wr_sel_r;
    rd_sel_nxt_s  = rd_sel_r;

    if (acc_s) begin
      if (drop_s) begin
        row_cnt_nxt_s = row_cnt_t'(1);
      end else if (done_s) begin
        row_cnt_nxt_s = ROW_FIRST;
      end else begin
        row_cnt_nxt_s = row_cnt_r + row_cnt_t'(1);
      end
    end else begin
      row_cnt_nxt_s = row_cnt_r;
    end

    // Consume and completion always address different banks, so both apply.
    if (cons_s) begin
      full_nxt_s[rd_sel_r] = 1'b0;
      rd_sel_nxt_s         = ~rd_sel_r;
    end else begin
      rd_sel_nxt_s = rd_sel_r;
    end

    if (done_s) begin
      full_nxt_s[wr_sel_r] = 1'b1;
      wr_sel_nxt_s         = ~wr_sel_r;
    end else begin
      wr_sel_nxt_s = wr_sel_r;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt_r   <= ROW_FIRST;
      full_r      <= 2'b00;
      wr_sel_r    <= 1'b0;
      rd_sel_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      row_cnt_r   <= row_cnt_nxt_s;
      full_r      <= full_nxt_s;
      wr_sel_r    <= wr_sel_nxt_s;
      rd_sel_r    <= rd_sel_nxt_s;
      frame_err_r <= drop_s;
    end
  end

  // Image banks: only the write bank changes, and only on an accepted row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank0_r <= {IWIDTH{1'b0}};
      bank1_r <= {IWIDTH{1'b0}};
    end else if (acc_s) begin
      if (wr_sel_r) begin
        bank1_r <= wbank_nxt_s;
      end else begin
        bank0_r <= wbank_nxt_s;
      end
    end else begin
      bank0_r <= bank0_r;
      bank1_r <= bank1_r;
    end
  end

endmodule

// File: tb/tb_image_row_assembler.sv
// Directed bench for image_row_assembler: hand-computed images, ping-pong
// handshakes, sof resynchronisation and mid-image reset.
module tb_image_row_assembler;

  logic        clk;
  logic        rst_n;
  logic        row_valid;
  logic        row_ready;
  logic        row_sof;
  logic [7:0]  row_data;
  logic        img_valid;
  logic        img_ready;
  logic [63:0] bank0;
  logic [63:0] bank1;
  logic        rd_sel;
  logic        frame_err;

  int checks;
  int errors;

  image_row_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_sof   (row_sof),
    .row_data  (row_data),
    .img_valid (img_valid),
    .img_ready (img_ready),
    .bank0     (bank0),
    .bank1     (bank1),
    .rd_sel    (rd_sel),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one row for exactly one edge.
  task automatic send_row(input logic [7:0] d, input logic sof);
    row_valid = 1'b1;
    row_data  = d;
    row_sof   = sof;
    tick();
    row_valid = 1'b0;
    row_sof   = 1'b0;
    row_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    row_valid = 1'b0;
    row_sof   = 1'b0;
    row_data  = 8'h00;
    img_ready = 1'b0;

    // 1: reset state, then the first image
    tick();
    tick();
    check("rst_row_ready", {63'd0, row_ready}, 64'd0);
    check("rst_img_valid", {63'd0, img_valid}, 64'd0);
    check("rst_bank0", bank0, 64'd0);
    check("rst_bank1", bank1, 64'd0);
    check("rst_rd_sel", {63'd0, rd_sel}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("t1_ready", {63'd0, row_ready}, 64'd1);
    send_row(8'h81, 1'b1);
    send_row(8'h42, 1'b0);
    send_row(8'h24, 1'b0);
    send_row(8'h18, 1'b0);
    send_row(8'h18, 1'b0);
    send_row(8'h24, 1'b0);
    send_row(8'h42, 1'b0);
    check("t1_valid_before_8th", {63'd0, img_valid}, 64'd0);
    send_row(8'h81, 1'b0);
    check("t1_img_valid", {63'd0, img_valid}, 64'd1);
    check("t1_bank0", bank0, 64'h8142241818244281);
    check("t1_rd_sel", {63'd0, rd_sel}, 64'd0);

    // 2: fill both banks with img_ready held low
    do_reset();
    for (int i = 0; i < 8; i++) send_row(8'h01 + 8'(i), (i == 0));
    for (int i = 0; i < 8; i++) send_row(8'h11 + 8'(i), (i == 0));
    check("t2_ready_both_full", {63'd0, row_ready}, 64'd0);
    send_row(8'hAA, 1'b1);
    check("t2_bank0", bank0, 64'h0102030405060708);
    check("t2_bank1", bank1, 64'h1112131415161718);
    check("t2_rd_sel_stable", {63'd0, rd_sel}, 64'd0);
    check("t2_img_valid", {63'd0, img_valid}, 64'd1);

    // 3: consume both images
    img_ready = 1'b1;
    tick();
    img_ready = 1'b0;
    #1;
    check("t3_rd_sel", {63'd0, rd_sel}, 64'd1);
    check("t3_img_valid", {63'd0, img_valid}, 64'd1);
    check("t3_row_ready", {63'd0, row_ready}, 64'd1);
    check("t3_bank1", bank1, 64'h1112131415161718);
    img_ready = 1'b1;
    tick();
    img_ready = 1'b0;
    #1;
    check("t3_img_valid_empty", {63'd0, img_valid}, 64'd0);
    check("t3_rd_sel_back", {63'd0, rd_sel}, 64'd0);

    // 4: sof in mid-image drops the partial image
    send_row(8'h33, 1'b1);
    send_row(8'h33, 1'b0);
    send_row(8'h33, 1'b0);
    check("t4_no_err_yet", {63'd0, frame_err}, 64'd0);
    send_row(8'hFF, 1'b1);
    check("t4_frame_err", {63'd0, frame_err}, 64'd1);
    check("t4_bank0_cleared", bank0, 64'hFF00000000000000);
    send_row(8'h01, 1'b0);
    check("t4_frame_err_pulse", {63'd0, frame_err}, 64'd0);
    for (int i = 1; i < 7; i++) send_row(8'h01 + 8'(i), 1'b0);
    check("t4_img_valid", {63'd0, img_valid}, 64'd1);
    check("t4_bank0", bank0, 64'hFF01020304050607);

    // 5: completion into bank1 on the same edge as consuming bank0
    for (int i = 0; i < 7; i++) send_row(8'h21 + 8'(i), (i == 0));
    check("t5_rd_sel_pre", {63'd0, rd_sel}, 64'd0);
    img_ready = 1'b1;
    send_row(8'h28, 1'b0);
    img_ready = 1'b0;
    #1;
    check("t5_rd_sel", {63'd0, rd_sel}, 64'd1);
    check("t5_img_valid", {63'd0, img_valid}, 64'd1);
    check("t5_row_ready", {63'd0, row_ready}, 64'd1);
    check("t5_bank1", bank1, 64'h2122232425262728);
    check("t5_bank0_kept", bank0, 64'hFF01020304050607);
    img_ready = 1'b1;
    tick();
    img_ready = 1'b0;
    #1;
    check("t5_empty", {63'd0, img_valid}, 64'd0);
    check("t5_rd_sel_back", {63'd0, rd_sel}, 64'd0);

    // 6: reset after five rows, then a fresh image
    for (int i = 0; i < 5; i++) send_row(8'h99, (i == 0));
    rst_n = 1'b0;
    tick();
    check("t6_rst_ready", {63'd0, row_ready}, 64'd0);
    check("t6_rst_bank0", bank0, 64'd0);
    check("t6_rst_bank1", bank1, 64'd0);
    check("t6_rst_img_valid", {63'd0, img_valid}, 64'd0);
    check("t6_rst_rd_sel", {63'd0, rd_sel}, 64'd0);
    check("t6_rst_frame_err", {63'd0, frame_err}, 64'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) send_row(8'h10 * 8'(i + 1), (i == 0));
    check("t6_valid_before_8th", {63'd0, img_valid}, 64'd0);
    send_row(8'h80, 1'b0);
    check("t6_img_valid", {63'd0, img_valid}, 64'd1);
    check("t6_bank0", bank0, 64'h1020304050607080);
    check("t6_rd_sel", {63'd0, rd_sel}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
